// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM encoding and access-legality helper
// for the RV32I load/store unit.
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCESS = 3'd1,
      S_WAIT   = 3'd2,
      S_DONE   = 3'd3,
      S_FAULT  = 3'd4
   } lsuState_e;

   // True when the access must be rejected (illegal code or misaligned).
   function automatic logic isFault(
      input logic       write,
      input logic [2:0] funct3,
      input logic [1:0] offset
   );
      logic illegal;
      logic misaligned;
      if (write)
         illegal = (funct3 > 3'd2);
      else
         illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      misaligned = ((funct3[1:0] == 2'b01) && offset[0])
                || ((funct3[1:0] == 2'b10) && (offset != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and memory-side signal bundle for the load/store unit.
// master = requester + memory, slave = load_store_unit.
interface load_store_unit_if;
   import load_store_unit_pkg::*;

   logic        iReq;
   logic        iWrite;
   logic [2:0]  iFunct3;
   logic [31:0] iAddress;
   logic [31:0] iStoreData;
   logic        oBusy;
   logic        oDone;
   logic        oMisaligned;
   logic [31:0] oLoadData;
   logic        oMemReadEnable;
   logic        oMemWriteEnable;
   logic [3:0]  oMemByteEnable;
   logic [31:0] oMemAddress;
   logic [31:0] oMemWriteData;
   logic [31:0] iMemReadData;

   modport master (
      output iReq, iWrite, iFunct3, iAddress, iStoreData, iMemReadData,
      input  oBusy, oDone, oMisaligned, oLoadData,
      input  oMemReadEnable, oMemWriteEnable, oMemByteEnable,
      input  oMemAddress, oMemWriteData
   );

   modport slave (
      input  iReq, iWrite, iFunct3, iAddress, iStoreData, iMemReadData,
      output oBusy, oDone, oMisaligned, oLoadData,
      output oMemReadEnable, oMemWriteEnable, oMemByteEnable,
      output oMemAddress, oMemWriteData
   );

endinterface

// File: rtl/load_store_unit_aligner.sv
// Combinational lane logic: byte enables and replicated store word,
// plus shift and sign/zero extension of the raw load word.
module lsu_data_aligner
   import load_store_unit_pkg::*;
(
   input  logic        write,
   input  logic [2:0]  funct3,
   input  logic [1:0]  byteOffset,
   input  logic [31:0] storeData,
   input  logic [31:0] rawData,
   output logic [3:0]  byteEnable,
   output logic [31:0] storeWord,
   output logic [31:0] loadWord
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   assign loadByte = rawData[{byteOffset, 3'b000} +: 8];
   assign loadHalf = byteOffset[1] ? rawData[31:16] : rawData[15:0];

   // Store lanes; loads always report all four lanes
   always_comb begin
      byteEnable = 4'b1111;
      storeWord  = storeData;
      if (write) begin
         case (funct3)
            F3_SB: begin
               byteEnable = 4'b0001 << byteOffset;
               storeWord  = {4{storeData[7:0]}};
            end
            F3_SH: begin
               byteEnable = 4'b0011 << {byteOffset[1], 1'b0};
               storeWord  = {2{storeData[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Load extraction and extension
   always_comb begin
      loadWord = rawData;
      case (funct3)
         F3_LB:   loadWord = {{24{loadByte[7]}}, loadByte};
         F3_LH:   loadWord = {{16{loadHalf[15]}}, loadHalf};
         F3_LBU:  loadWord = {24'd0, loadByte};
         F3_LHU:  loadWord = {16'd0, loadHalf};
         default: loadWord = rawData;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store sequencer: latches a request,
// drives the memory port, waits out the read latency, returns data.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input logic              iCLK,
   input logic              iRST,
   load_store_unit_if.slave bus
);

   localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

   lsuState_e   state;
   lsuState_e   nextState;
   logic [2:0]  count;
   logic        reqWrite;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddress;
   logic [31:0] reqStoreData;
   logic [31:0] loadData;
   logic [3:0]  alignBe;
   logic [31:0] alignStore;
   logic [31:0] alignLoad;
   logic        active;
   logic        capture;

   assign active  = (state == S_ACCESS) || (state == S_WAIT);
   assign capture = active && (count == 3'd0);

   lsu_data_aligner aligner (
      .write      (reqWrite),
      .funct3     (reqFunct3),
      .byteOffset (reqAddress[1:0]),
      .storeData  (reqStoreData),
      .rawData    (bus.iMemReadData),
      .byteEnable (alignBe),
      .storeWord  (alignStore),
      .loadWord   (alignLoad)
   );

   // FSM state register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= S_IDLE;
      else      state <= nextState;
   end

   // Request latches, latency counter and load result register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         count        <= 3'd0;
         reqWrite     <= 1'b0;
         reqFunct3    <= 3'd0;
         reqAddress   <= 32'd0;
         reqStoreData <= 32'd0;
         loadData     <= 32'd0;
      end else begin
         if ((state == S_IDLE) && bus.iReq) begin
            reqWrite     <= bus.iWrite;
            reqFunct3    <= bus.iFunct3;
            reqAddress   <= bus.iAddress;
            reqStoreData <= bus.iStoreData;
            count        <= LAT_INIT;
         end else if (active && (count != 3'd0)) begin
            count <= count - 3'd1;
         end
         if (capture && !reqWrite) loadData <= alignLoad;
      end
   end

   // Next-state and output decode
   always_comb begin
      nextState           = state;
      bus.oBusy           = (state != S_IDLE);
      bus.oDone           = 1'b0;
      bus.oMisaligned     = 1'b0;
      bus.oLoadData       = loadData;
      bus.oMemReadEnable  = 1'b0;
      bus.oMemWriteEnable = 1'b0;
      bus.oMemByteEnable  = 4'd0;
      bus.oMemAddress     = reqAddress;
      bus.oMemWriteData   = 32'd0;
      case (state)
         S_IDLE: begin
            if (bus.iReq)
               nextState = isFault(bus.iWrite, bus.iFunct3, bus.iAddress[1:0])
                         ? S_FAULT : S_ACCESS;
         end
         S_ACCESS, S_WAIT: begin
            bus.oMemReadEnable  = !reqWrite;
            bus.oMemWriteEnable = reqWrite && (state == S_ACCESS);
            bus.oMemByteEnable  = alignBe;
            bus.oMemWriteData   = alignStore;
            nextState = capture ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            bus.oDone = 1'b1;
            nextState = S_IDLE;
         end
         S_FAULT: begin
            bus.oDone       = 1'b1;
            bus.oMisaligned = 1'b1;
            nextState       = S_IDLE;
         end
         default: nextState = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with latency-1 and
// latency-3 instances sharing one byte-lane memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [2:0]  f3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] sdata = 32'd0;
   logic [31:0] mem [0:15];
   int          age3;
   int          passCount = 0;
   int          totalCount = 0;

   always #5 clk = ~clk;

   load_store_unit_if bus1 ();
   load_store_unit_if bus3 ();

   load_store_unit #(.MEM_LATENCY(1)) dut1 (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus1)
   );

   load_store_unit #(.MEM_LATENCY(3)) dut3 (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus3)
   );

   assign bus1.iReq       = req & ~sel;
   assign bus3.iReq       = req & sel;
   assign bus1.iWrite     = wr;
   assign bus3.iWrite     = wr;
   assign bus1.iFunct3    = f3;
   assign bus3.iFunct3    = f3;
   assign bus1.iAddress   = addr;
   assign bus3.iAddress   = addr;
   assign bus1.iStoreData = sdata;
   assign bus3.iStoreData = sdata;

   // Latency-1 memory: word valid in the enable cycle; latency-3: garbage
   // until the third consecutive enable cycle.
   assign bus1.iMemReadData = bus1.oMemReadEnable
                            ? mem[bus1.oMemAddress[5:2]] : 32'hDEADBEEF;
   assign bus3.iMemReadData = (bus3.oMemReadEnable && age3 >= 2)
                            ? mem[bus3.oMemAddress[5:2]] : 32'hDEADBEEF;

   always @(posedge clk) begin
      age3 <= bus3.oMemReadEnable ? age3 + 1 : 0;
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bus1.oMemWriteEnable && bus1.oMemByteEnable[b])
               mem[bus1.oMemAddress[5:2]][8*b +: 8] <= bus1.oMemWriteData[8*b +: 8];
            if (bus3.oMemWriteEnable && bus3.oMemByteEnable[b])
               mem[bus3.oMemAddress[5:2]][8*b +: 8] <= bus3.oMemWriteData[8*b +: 8];
         end
      end
   end

   logic        selBusy, selDone, selMis, selRe, selWe;
   logic [3:0]  selBe;
   logic [31:0] selLoad, selWd;
   assign selBusy = sel ? bus3.oBusy : bus1.oBusy;
   assign selDone = sel ? bus3.oDone : bus1.oDone;
   assign selMis  = sel ? bus3.oMisaligned : bus1.oMisaligned;
   assign selRe   = sel ? bus3.oMemReadEnable : bus1.oMemReadEnable;
   assign selWe   = sel ? bus3.oMemWriteEnable : bus1.oMemWriteEnable;
   assign selBe   = sel ? bus3.oMemByteEnable : bus1.oMemByteEnable;
   assign selLoad = sel ? bus3.oLoadData : bus1.oLoadData;
   assign selWd   = sel ? bus3.oMemWriteData : bus1.oMemWriteData;

   typedef struct {
      logic        write;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      int          cyc;
      logic        mis;
      logic [31:0] ld;
      int          wrCnt;
      int          rdCnt;
      logic [3:0]  be;
      logic [31:0] wd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic runAccess(
      input  logic        w,
      input  logic [2:0]  f,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic        toggleReq,
      output int          cyc,
      output logic        mis,
      output logic [31:0] ld,
      output int          wrCnt,
      output int          rdCnt,
      output logic [3:0]  be,
      output logic [31:0] wd,
      output logic        done
   );
      @(negedge clk);
      wr = w; f3 = f; addr = a; sdata = d; req = 1'b1;
      cyc = 0; done = 1'b0; mis = 1'b0; ld = 32'd0;
      wrCnt = 0; rdCnt = 0; be = 4'd0; wd = 32'd0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (selWe) begin wrCnt++; be = selBe; wd = selWd; end
         if (selRe) begin rdCnt++; be = selBe; end
         if (selDone) begin
            done = 1'b1; mis = selMis; ld = selLoad;
         end else if (toggleReq) begin
            req = ~req;
         end
      end
      req = 1'b0;
   endtask

   initial begin
      int          cyc, wrCnt, rdCnt;
      logic        mis, done;
      logic [31:0] ld, wd;
      logic [3:0]  be;

      vecs.push_back('{1, 3'd2, 32'h10010000, 32'h8081F2F3, 2, 0, 32'h0, 1, 0, 4'hF, 32'h8081F2F3});
      vecs.push_back('{1, 3'd2, 32'h10010010, 32'h12345678, 2, 0, 32'h0, 1, 0, 4'hF, 32'h12345678});
      vecs.push_back('{0, 3'd0, 32'h10010002, 32'h0, 2, 0, 32'hFFFFFF81, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd4, 32'h10010002, 32'h0, 2, 0, 32'h00000081, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd1, 32'h10010000, 32'h0, 2, 0, 32'hFFFFF2F3, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd5, 32'h10010002, 32'h0, 2, 0, 32'h00008081, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd2, 32'h10010000, 32'h0, 2, 0, 32'h8081F2F3, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd0, 32'h10010001, 32'h0, 2, 0, 32'hFFFFFFF2, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd4, 32'h10010003, 32'h0, 2, 0, 32'h00000080, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd2, 32'h10010002, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{0, 3'd1, 32'h10010001, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{0, 3'd5, 32'h10010003, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{0, 3'd3, 32'h10010000, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{0, 3'd6, 32'h10010000, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{0, 3'd7, 32'h10010000, 32'h0, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{1, 3'd4, 32'h10010000, 32'hFFFFFFFF, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{1, 3'd7, 32'h10010000, 32'hFFFFFFFF, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{1, 3'd2, 32'h10010002, 32'hFFFFFFFF, 1, 1, 32'h00000080, 0, 0, 4'h0, 32'h0});
      vecs.push_back('{1, 3'd0, 32'h10010003, 32'h000000A5, 2, 0, 32'h00000080, 1, 0, 4'h8, 32'hA5A5A5A5});
      vecs.push_back('{1, 3'd1, 32'h10010006, 32'h1234BEEF, 2, 0, 32'h00000080, 1, 0, 4'hC, 32'hBEEFBEEF});
      vecs.push_back('{1, 3'd2, 32'h10010008, 32'hCAFEF00D, 2, 0, 32'h00000080, 1, 0, 4'hF, 32'hCAFEF00D});
      vecs.push_back('{1, 3'd0, 32'h10010004, 32'h0000003C, 2, 0, 32'h00000080, 1, 0, 4'h1, 32'h3C3C3C3C});
      vecs.push_back('{0, 3'd2, 32'h10010000, 32'h0, 2, 0, 32'hA581F2F3, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd2, 32'h10010004, 32'h0, 2, 0, 32'hBEEF003C, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd1, 32'h10010006, 32'h0, 2, 0, 32'hFFFFBEEF, 0, 1, 4'hF, 32'h0});
      vecs.push_back('{0, 3'd0, 32'h10010009, 32'h0, 2, 0, 32'hFFFFFFF0, 0, 1, 4'hF, 32'h0});

      repeat (2) @(negedge clk);
      chk("reset busy", {31'd0, selBusy}, 32'd0);
      chk("reset done", {31'd0, selDone}, 32'd0);
      chk("reset misaligned", {31'd0, selMis}, 32'd0);
      chk("reset loaddata", selLoad, 32'd0);
      chk("reset byteenable", {28'd0, selBe}, 32'd0);
      chk("reset enables", {30'd0, selRe, selWe}, 32'd0);
      chk("reset address", bus1.oMemAddress, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         runAccess(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].sdata, 1'b0,
                   cyc, mis, ld, wrCnt, rdCnt, be, wd, done);
         chk($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
         chk($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
         chk($sformatf("v%0d misaligned", i), {31'd0, mis}, {31'd0, vecs[i].mis});
         chk($sformatf("v%0d loaddata", i), ld, vecs[i].ld);
         chk($sformatf("v%0d writecycles", i), wrCnt, vecs[i].wrCnt);
         chk($sformatf("v%0d readcycles", i), rdCnt, vecs[i].rdCnt);
         if (wrCnt + rdCnt > 0)
            chk($sformatf("v%0d byteenable", i), {28'd0, be}, {28'd0, vecs[i].be});
         if (wrCnt > 0)
            chk($sformatf("v%0d writedata", i), wd, vecs[i].wd);
      end

      // Latency 3 load with iReq toggling while busy
      sel = 1'b1;
      runAccess(1'b0, 3'd2, 32'h10010010, 32'h0, 1'b1,
                cyc, mis, ld, wrCnt, rdCnt, be, wd, done);
      chk("lat3 done", {31'd0, done}, 32'd1);
      chk("lat3 cycles", cyc, 4);
      chk("lat3 loaddata", ld, 32'h12345678);
      chk("lat3 readcycles", rdCnt, 3);
      chk("lat3 writecycles", wrCnt, 0);
      @(negedge clk);
      chk("lat3 idle after", {31'd0, selBusy}, 32'd0);

      // Reset in the middle of a latency 3 load
      @(negedge clk);
      wr = 1'b0; f3 = 3'd2; addr = 32'h10010010; req = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort wait readenable", {31'd0, selRe}, 32'd1);
      req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("abort readenable", {31'd0, selRe}, 32'd0);
      chk("abort busy", {31'd0, selBusy}, 32'd0);
      chk("abort loaddata", selLoad, 32'd0);
      chk("abort byteenable", {28'd0, selBe}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      runAccess(1'b1, 3'd2, 32'h1001000C, 32'h0BADF00D, 1'b0,
                cyc, mis, ld, wrCnt, rdCnt, be, wd, done);
      chk("post sw done", {31'd0, done}, 32'd1);
      chk("post sw cycles", cyc, 4);
      chk("post sw writecycles", wrCnt, 1);
      chk("post sw writedata", wd, 32'h0BADF00D);
      chk("post sw byteenable", {28'd0, be}, 32'hF);
      @(negedge clk);
      chk("post sw memory", mem[3], 32'h0BADF00D);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
